// File: rtl/genius_sequencia_param.sv
// genius_sequencia_param: Genius memory-game core.
// Keeps a random sequence in an internal RAM, grows it by one step per round,
// plays it back on the LEDs and then checks the player's presses against it.
// Optional feature macro: GENIUS_TIMEOUT_EN (per-press time limit -> FIM_TIMEOUT).
// Ports:
//   clock, reset     clock and asynchronous active-high reset
//   jogar            start/restart request, honoured in INICIAL and FIM_*
//   dificuldade      0: game ends at PROF/2 steps, 1: at PROF steps (latched)
//   botoes           player buttons, active-high, already synchronised
//   leds             one-hot playback, or echo of the buttons while waiting
//   pontuacao        rounds completed in the current/last game
//   estado           FSM state code (debug)
//   db_esperado      one-hot step currently expected (debug)
//   pronto/ganhou/perdeu  game over / won / lost
module genius_sequencia_param #(
    parameter int unsigned N_BOTOES  = 4,
    parameter int unsigned PROF      = 16,
    parameter int unsigned T_ACESO   = 25000,
    parameter int unsigned T_APAGADO = 12500,
    parameter int unsigned T_LIMITE  = 250000,
    parameter logic [15:0] SEMENTE   = 16'hACE1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        jogar,
    input  logic                        dificuldade,
    input  logic [N_BOTOES-1:0]         botoes,
    output logic [N_BOTOES-1:0]         leds,
    output logic [$clog2(PROF+1)-1:0]   pontuacao,
    output logic [3:0]                  estado,
    output logic [N_BOTOES-1:0]         db_esperado,
    output logic                        pronto,
    output logic                        ganhou,
    output logic                        perdeu
);

    localparam int unsigned NB    = N_BOTOES;
    localparam int unsigned IW    = $clog2(N_BOTOES);
    localparam int unsigned AW    = $clog2(PROF);
    localparam int unsigned TAMW  = $clog2(PROF + 1);
    localparam int unsigned T_VIS = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
`ifdef GENIUS_TIMEOUT_EN
    localparam int unsigned T_MAX = (T_LIMITE > T_VIS) ? T_LIMITE : T_VIS;
`else
    // T_LIMITE has no effect in this build; referenced so both builds share one parameter list.
    localparam int unsigned T_MAX = T_VIS + (T_LIMITE - T_LIMITE);
`endif
    localparam int unsigned TW    = $clog2(T_MAX + 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        PREPARA     = 4'd1,
        GERA        = 4'd2,
        MOSTRA      = 4'd3,
        INTERVALO   = 4'd4,
        ESPERA      = 4'd5,
        COMPARA     = 4'd6,
        PROXIMA     = 4'd7,
        FIM_ACERTO  = 4'd8,
        FIM_ERRO    = 4'd9,
        FIM_TIMEOUT = 4'd10
    } estado_t;

    estado_t           estado_q, estado_d;
    logic [TAMW-1:0]   tamanho_q, tamanho_d;
    logic [AW-1:0]     endereco_q, endereco_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [NB-1:0]     press_q, press_d;
    logic              dific_q, dific_d;
    logic [TAMW-1:0]   pontuacao_q, pontuacao_d;
    logic [15:0]       lfsr_q;
    logic [NB-1:0]     botoes_ant_q;
    logic [NB-1:0]     leds_q, leds_d;
    logic [NB-1:0]     db_q, db_d;
    logic              pronto_q, pronto_d, ganhou_q, ganhou_d, perdeu_q, perdeu_d;
    logic [IW-1:0]     ram_q [PROF];

    logic [IW-1:0]     indice_c, rd_c;
    logic [NB-1:0]     esperado_c, onehot_c;
    logic              press_c, ultimo_c, grava_c;
    logic [TAMW-1:0]   limite_c;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1 (right-shifting form)
    logic [15:0] lfsr_prox_c;
    assign lfsr_prox_c = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    assign indice_c   = IW'({1'b0, lfsr_q[2:0]} % 4'(N_BOTOES));
    assign press_c    = (|botoes) && !(|botoes_ant_q);
    assign limite_c   = dific_q ? TAMW'(PROF) : TAMW'(PROF / 2);
    assign ultimo_c   = (TAMW'(endereco_q) == tamanho_q - TAMW'(1));
    assign esperado_c = NB'(1) << ram_q[endereco_q];

    // Next-state, datapath updates and next values of the registered outputs
    always_comb begin
        estado_d    = estado_q;
        tamanho_d   = tamanho_q;
        endereco_d  = endereco_q;
        timer_d     = timer_q;
        press_d     = press_q;
        dific_d     = dific_q;
        pontuacao_d = pontuacao_q;
        grava_c     = 1'b0;
        rd_c        = '0;
        onehot_c    = '0;
        leds_d      = '0;
        db_d        = '0;

        case (estado_q)
            INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (jogar) estado_d = PREPARA;
            end
            PREPARA: begin
                tamanho_d   = '0;
                pontuacao_d = '0;
                dific_d     = dificuldade;
                estado_d    = GERA;
            end
            GERA: begin
                grava_c    = 1'b1;
                tamanho_d  = tamanho_q + TAMW'(1);
                endereco_d = '0;
                timer_d    = '0;
                estado_d   = MOSTRA;
            end
            MOSTRA: begin
                if (timer_q == TW'(T_ACESO - 1)) begin
                    timer_d  = '0;
                    estado_d = INTERVALO;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            INTERVALO: begin
                if (timer_q == TW'(T_APAGADO - 1)) begin
                    timer_d = '0;
                    if (ultimo_c) begin
                        endereco_d = '0;
                        estado_d   = ESPERA;
                    end else begin
                        endereco_d = endereco_q + AW'(1);
                        estado_d   = MOSTRA;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ESPERA: begin
                // A press wins over a simultaneous timer expiry
                if (press_c) begin
                    press_d  = botoes;
                    timer_d  = '0;
                    estado_d = COMPARA;
                end
`ifdef GENIUS_TIMEOUT_EN
                else if (timer_q == TW'(T_LIMITE - 1)) begin
                    estado_d = FIM_TIMEOUT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
`endif
            end
            COMPARA: begin
                // Exact equality with a one-hot value also rejects multi-button presses
                if (press_q != esperado_c) begin
                    estado_d = FIM_ERRO;
                end else if (!ultimo_c) begin
                    endereco_d = endereco_q + AW'(1);
                    timer_d    = '0;
                    estado_d   = ESPERA;
                end else begin
                    pontuacao_d = tamanho_q;
                    estado_d    = PROXIMA;
                end
            end
            PROXIMA: begin
                estado_d = (tamanho_q == limite_c) ? FIM_ACERTO : GERA;
            end
            default: estado_d = INICIAL;
        endcase

        // Step shown/expected next cycle; bypass the RAM for the entry written this cycle
        if (grava_c && (TAMW'(endereco_d) == tamanho_q)) rd_c = indice_c;
        else                                            rd_c = ram_q[endereco_d];
        onehot_c = NB'(1) << rd_c;

        case (estado_d)
            MOSTRA:          leds_d = onehot_c;
            ESPERA, COMPARA: begin
                leds_d = botoes;
                db_d   = onehot_c;
            end
            default: ;
        endcase
        pronto_d = (estado_d == FIM_ACERTO) || (estado_d == FIM_ERRO) || (estado_d == FIM_TIMEOUT);
        ganhou_d = (estado_d == FIM_ACERTO);
        perdeu_d = (estado_d == FIM_ERRO) || (estado_d == FIM_TIMEOUT);
    end

    // State, datapath and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q     <= INICIAL;
            tamanho_q    <= '0;
            endereco_q   <= '0;
            timer_q      <= '0;
            press_q      <= '0;
            dific_q      <= 1'b0;
            pontuacao_q  <= '0;
            lfsr_q       <= SEMENTE;
            botoes_ant_q <= '0;
            leds_q       <= '0;
            db_q         <= '0;
            pronto_q     <= 1'b0;
            ganhou_q     <= 1'b0;
            perdeu_q     <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            tamanho_q    <= tamanho_d;
            endereco_q   <= endereco_d;
            timer_q      <= timer_d;
            press_q      <= press_d;
            dific_q      <= dific_d;
            pontuacao_q  <= pontuacao_d;
            lfsr_q       <= lfsr_prox_c;
            botoes_ant_q <= botoes;
            leds_q       <= leds_d;
            db_q         <= db_d;
            pronto_q     <= pronto_d;
            ganhou_q     <= ganhou_d;
            perdeu_q     <= perdeu_d;
        end
    end

    // Sequence RAM, written once per round
    always_ff @(posedge clock) begin
        if (grava_c) ram_q[AW'(tamanho_q)] <= indice_c;
    end

    assign leds        = leds_q;
    assign pontuacao   = pontuacao_q;
    assign estado      = estado_q;
    assign db_esperado = db_q;
    assign pronto      = pronto_q;
    assign ganhou      = ganhou_q;
    assign perdeu      = perdeu_q;

endmodule

// File: tb/tb_genius_sequencia_param.sv
// Bench for genius_sequencia_param: the driver predicts every state change of the
// game cycle by cycle and queues the expected outputs; a monitor compares them
// whenever the DUT changes state (or at a queued probe cycle).
module tb_genius_sequencia_param;

    localparam int unsigned NB   = 4;
    localparam int unsigned PROF = 4;
    localparam int unsigned TA   = 3;
    localparam int unsigned TP   = 2;
    localparam int unsigned TL   = 20;
    localparam int unsigned PW   = $clog2(PROF + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          jogar = 1'b0;
    logic          dific = 1'b0;
    logic [NB-1:0] botoes = '0;
    logic [NB-1:0] leds, db_esperado;
    logic [PW-1:0] pontuacao;
    logic [3:0]    estado;
    logic          pronto, ganhou, perdeu;

    genius_sequencia_param #(
        .N_BOTOES(NB), .PROF(PROF), .T_ACESO(TA), .T_APAGADO(TP),
        .T_LIMITE(TL), .SEMENTE(16'hACE1)
    ) dut (
        .clock(clk), .reset(rst), .jogar(jogar), .dificuldade(dific),
        .botoes(botoes), .leds(leds), .pontuacao(pontuacao), .estado(estado),
        .db_esperado(db_esperado), .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  est;
        logic [3:0]  leds;
        logic [2:0]  pont;
        logic [3:0]  db;
        logic        pronto;
        logic        ganhou;
        logic        perdeu;
    } rec_t;

    rec_t q_trans[$];
    rec_t q_probe[$];
    int   asserts = 0;
    int   fails   = 0;
    bit   final_req = 1'b0;
    bit   final_done = 1'b0;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR, textbook form for seed 0xACE1 with taps 16,14,13,11
    logic [15:0] lfsr_m;
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= (lfsr_m >> 1) | (16'(((lfsr_m >> 0) ^ (lfsr_m >> 2) ^ (lfsr_m >> 3) ^ (lfsr_m >> 5)) & 16'd1) << 15);
    end

    int         tam = 0;
    int         pont = 0;
    logic [1:0] seq[$];

    function automatic logic [3:0] oh(input logic [1:0] i);
        logic [3:0] v;
        v = 4'b0001 << i;
        return v;
    endfunction

    function automatic rec_t mk(input logic [3:0] est, input logic [3:0] l, input logic [3:0] db);
        rec_t r;
        r.cyc    = cyc;
        r.est    = est;
        r.leds   = l;
        r.pont   = 3'(pont);
        r.db     = db;
        r.pronto = (est >= 4'd8);
        r.ganhou = (est == 4'd8);
        r.perdeu = (est == 4'd9) || (est == 4'd10);
        return r;
    endfunction

    task automatic push_t(input logic [3:0] est, input logic [3:0] l, input logic [3:0] db);
        q_trans.push_back(mk(est, l, db));
    endtask

    task automatic push_p(input logic [3:0] est, input logic [3:0] l, input logic [3:0] db);
        q_probe.push_back(mk(est, l, db));
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares on every state change and at queued probe cycles
    initial begin
        logic [3:0] prev_est;
        rec_t       act, ex;
        prev_est = 4'd0;
        forever begin
            @(negedge clk);
            act = '{cyc: cyc, est: estado, leds: leds, pont: 3'(pontuacao), db: db_esperado,
                    pronto: pronto, ganhou: ganhou, perdeu: perdeu};
            if (estado !== prev_est) begin
                prev_est = estado;
                asserts++;
                if (q_trans.size() == 0) begin
                    fails++;
                    $display("FAIL transition: unexpected change to estado=%0d at cycle %0d (nothing expected)", estado, cyc);
                end else begin
                    ex = q_trans.pop_front();
                    if (act !== ex) begin
                        fails++;
                        $display("FAIL transition: got cyc=%0d est=%0d leds=%b pont=%0d db=%b pgp=%b%b%b, want cyc=%0d est=%0d leds=%b pont=%0d db=%b pgp=%b%b%b",
                                 act.cyc, act.est, act.leds, act.pont, act.db, act.pronto, act.ganhou, act.perdeu,
                                 ex.cyc, ex.est, ex.leds, ex.pont, ex.db, ex.pronto, ex.ganhou, ex.perdeu);
                    end
                end
            end
            if (q_probe.size() != 0 && q_probe[0].cyc == 32'(cyc)) begin
                ex = q_probe.pop_front();
                asserts++;
                if (act !== ex) begin
                    fails++;
                    $display("FAIL probe: got cyc=%0d est=%0d leds=%b pont=%0d db=%b pgp=%b%b%b, want cyc=%0d est=%0d leds=%b pont=%0d db=%b pgp=%b%b%b",
                             act.cyc, act.est, act.leds, act.pont, act.db, act.pronto, act.ganhou, act.perdeu,
                             ex.cyc, ex.est, ex.leds, ex.pont, ex.db, ex.pronto, ex.ganhou, ex.perdeu);
                end
            end
            if (final_req && !final_done) begin
                asserts++;
                if (q_trans.size() != 0 || q_probe.size() != 0) begin
                    fails++;
                    $display("FAIL leftover: %0d transitions and %0d probes never seen, want 0 and 0",
                             q_trans.size(), q_probe.size());
                end
                final_done = 1'b1;
            end
        end
    end

    task automatic do_reset();
        pont = 0;
        push_t(4'd0, 4'd0, 4'd0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start_game(input bit dif);
        dific = dif;
        jogar = 1'b1;
        tick();
        jogar = 1'b0;
        push_t(4'd1, 4'd0, 4'd0);
        tick();
        pont = 0;
        tam  = 0;
        seq.delete();
        push_t(4'd2, 4'd0, 4'd0);
    endtask

    // Full game; fail_val==0 means "wrong single button" at the failing step
    task automatic play_game(input bit dif, input bit flip, input int fail_round,
                             input int fail_step, input logic [3:0] fail_val, input bit idle);
        int         limite;
        bit         done;
        logic [3:0] v, e;
        limite = dif ? int'(PROF) : int'(PROF / 2);
        done   = 1'b0;
        start_game(dif);
        for (int r = 1; r <= int'(PROF) && !done; r++) begin
            seq.push_back(lfsr_m[1:0]);
            tam++;
            if (flip && r == 1) dific = ~dif;
            tick();
            for (int k = 0; k < tam; k++) begin
                push_t(4'd3, oh(seq[k]), 4'd0);
                repeat (TA) tick();
                push_t(4'd4, 4'd0, 4'd0);
                repeat (TP) tick();
            end
            push_t(4'd5, 4'd0, oh(seq[0]));
            if (idle) begin
`ifdef GENIUS_TIMEOUT_EN
                repeat (TL) tick();
                push_t(4'd10, 4'd0, 4'd0);
`else
                repeat (TL + 5) tick();
                push_p(4'd5, 4'd0, oh(seq[0]));
`endif
                done = 1'b1;
            end else begin
                for (int s = 0; s < tam && !done; s++) begin
                    e = oh(seq[s]);
                    v = e;
                    if (r == fail_round && s == fail_step) v = (fail_val != 4'd0) ? fail_val : {e[2:0], e[3]};
                    botoes = v;
                    tick();
                    push_t(4'd6, v, e);
                    botoes = '0;
                    tick();
                    if (v != e) begin
                        push_t(4'd9, 4'd0, 4'd0);
                        done = 1'b1;
                    end else if (s < tam - 1) begin
                        push_t(4'd5, 4'd0, oh(seq[s + 1]));
                    end else begin
                        pont = tam;
                        push_t(4'd7, 4'd0, 4'd0);
                        tick();
                        if (tam == limite) begin
                            push_t(4'd8, 4'd0, 4'd0);
                            done = 1'b1;
                        end else begin
                            push_t(4'd2, 4'd0, 4'd0);
                        end
                    end
                end
            end
        end
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        push_p(4'd0, 4'd0, 4'd0);
        tick();
        rst = 1'b0;
        tick();

        play_game(1'b1, 1'b0, 0, 0, 4'd0, 1'b0);      // hard, all correct: 4 rounds
        play_game(1'b0, 1'b1, 0, 0, 4'd0, 1'b0);      // easy, difficulty flipped mid-game
        play_game(1'b1, 1'b0, 2, 1, 4'd0, 1'b0);      // wrong button, round 2 step 2
        play_game(1'b1, 1'b0, 1, 0, 4'b0011, 1'b0);   // two buttons at once
        play_game(1'b1, 1'b0, 0, 0, 4'd0, 1'b1);      // no press in ESPERA
`ifndef GENIUS_TIMEOUT_EN
        do_reset();
`endif
        // Reset in the middle of playback
        start_game(1'b1);
        seq.push_back(lfsr_m[1:0]);
        tick();
        push_t(4'd3, oh(seq[0]), 4'd0);
        tick();
        do_reset();
        play_game(1'b0, 1'b0, 0, 0, 4'd0, 1'b0);      // recovery after reset

        repeat (3) tick();
        final_req = 1'b1;
        for (int i = 0; i < 10 && !final_done; i++) tick();
        if (!final_done) begin
            $display("FAIL final: monitor did not complete its closing check");
            $fatal(1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
